// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   UART receive front end clocked at OVERSAMPLE x baud. rxd is brought in through a two-flop
//   synchroniser, each bit is majority-voted from three samples around mid-bit, and 8N1-style
//   frames (DATA_BITS data bits, LSB first) are assembled and handed to the control stage.
// Ports
//   clk        in   16x-baud clock, all logic on posedge
//   reset      in   asynchronous, active-high; clears all state
//   rxd        in   serial line, idle high, asynchronous to clk
//   rx_data    out  data of the last completed frame, held until the next frame completes
//   rx_status  out  1 = idle/done, 0 = frame in progress (falls once the start bit is validated)
//   rx_valid   out  one-cycle pulse when a frame with a good stop bit completes
//   frame_err  out  1 = last frame had a low stop bit; cleared by the next good frame
module uart_rx_sampler #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_status,
    output logic                 rx_valid,
    output logic                 frame_err
);

    localparam int unsigned MID  = OVERSAMPLE / 2;
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntS0   = CntW'(MID - 1);
    localparam logic [CntW-1:0] CntS1   = CntW'(MID);
    localparam logic [CntW-1:0] CntS2   = CntW'(MID + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             samp_q, samp_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   status_q, status_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    logic rxd_s;
    logic s2;
    logic vote;

    assign rxd_s = sync_q[1];

    // STOP exits on the cycle of the third sample, so that sample is taken live from rxd_s.
    assign s2   = (cnt_q == CntS2) ? rxd_s : samp_q[2];
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2) | (samp_q[1] & s2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            armed_q   <= 1'b0;
            rx_data_q <= '0;
            status_q  <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            armed_q   <= armed_d;
            rx_data_q <= rx_data_d;
            status_q  <= status_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        armed_d   = armed_q;
        rx_data_d = rx_data_q;
        status_d  = status_q;
        valid_d   = 1'b0;
        ferr_d    = ferr_q;

        if (state_q != StIdle) begin
            if (cnt_q == CntS0) samp_d[0] = rxd_s;
            if (cnt_q == CntS1) samp_d[1] = rxd_s;
            if (cnt_q == CntS2) samp_d[2] = rxd_s;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A start edge only counts after the line has been seen high (break guard).
                if (rxd_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (vote) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StData;
                        idx_d    = '0;
                        status_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IdxLast) state_d = StStop;
                end
            end
            StStop: begin
                // Arming during the stop bit lets a back-to-back start edge be taken at once.
                if (rxd_s) armed_d = 1'b1;
                if (cnt_q == CntS2) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    rx_data_d = shift_q;
                    status_d  = 1'b1;
                    if (vote) begin
                        valid_d = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_status = status_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: directed frames with a scoreboard queue of expected results,
// checked by an independent monitor on every rx_status edge.
module tb_uart_rx_sampler;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_valid;
    logic       frame_err;

    uart_rx_sampler #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    bit   abort_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Start bit is driven at the negedge after edge k; the DUT sees it in IDLE at edge k+3,
    // so rx_status falls at k+19 and the frame completes at k+157.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int unsigned pa, input int unsigned pb);
        logic [9:0] bits;
        exp_t       e;
        bits   = {stop_bit, data, 1'b0};
        e.data = data;
        e.err  = ~stop_bit;
        e.due  = cyc + 157;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat ((i % 2 == 0) ? pa : pb) @(negedge clk);
        end
    endtask

    // Monitor
    initial begin
        bit   prev = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
            end else begin
                if (prev && !rx_status) begin
                    if (sb.size() != 0) chk("status_fall_cycle", cyc, sb[0].due - 138);
                    else if (!abort_ok) chk("unexpected_start_rx_status", rx_status, 1);
                end else if (!prev && rx_status) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_frame_rx_status", rx_status, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rx_data", rx_data, e.data);
                        chk("rx_valid", rx_valid, !e.err);
                        chk("frame_err", frame_err, e.err);
                        chk("done_cycle", cyc, e.due);
                    end
                end else if (rx_valid) begin
                    chk("stray_rx_valid", rx_valid, 0);
                end
                prev = rx_status;
            end
        end
    end

    initial begin
        bit glitch_low;

        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_status", rx_status, 1);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single frame
        send_frame(8'h55, 1'b1, 16, 16);
        repeat (20) @(negedge clk);

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b1, 16, 16);
        send_frame(8'h3C, 1'b1, 16, 16);
        repeat (20) @(negedge clk);

        // Short low glitch must be rejected in START
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        glitch_low = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!rx_status) glitch_low = 1'b1;
        end
        chk("glitch_rx_status_low_seen", glitch_low, 0);
        chk("glitch_rx_data_held", rx_data, 8'h3C);

        // Framing error followed by a 40-bit break, then a good frame
        send_frame(8'h81, 1'b0, 16, 16);
        repeat (40 * 16) @(negedge clk);
        chk("break_frame_err_held", frame_err, 1);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h42, 1'b1, 16, 16);
        repeat (20) @(negedge clk);

        // Reset during bit 4 of 0xFF
        abort_ok = 1'b1;
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_rx_data", rx_data, 8'h00);
        chk("midreset_rx_status", rx_status, 1);
        chk("midreset_rx_valid", rx_valid, 0);
        chk("midreset_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        abort_ok = 1'b0;
        send_frame(8'h12, 1'b1, 16, 16);
        repeat (20) @(negedge clk);

        // Baud mismatch: slow side 17 clk/bit; fast side alternates 15/16 clk/bit, since a flat
        // 15 clk/bit drifts past the sample window by bit 6 with a 16x receiver.
        send_frame(8'h96, 1'b1, 17, 17);
        repeat (20) @(negedge clk);
        send_frame(8'h96, 1'b1, 15, 16);

        repeat (400) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drain_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
